// File: rtl/gam_winner_search_if.sv
// Request/write/result bundle of the GAM winner-search engine.
// The master side drives node writes and search requests; the slave side returns results.
interface gam_winner_search_if #(
  parameter int NODE_COUNT  = 10,
  parameter int CLASS_COUNT = 4,
  parameter int VECTOR_LEN  = 4,
  parameter int PIXEL_W     = 8
);
  localparam int NIDX_W = $clog2(NODE_COUNT + 1);
  localparam int CIDX_W = $clog2(CLASS_COUNT + 1);
  localparam int DIST_W = 2 * PIXEL_W + $clog2(VECTOR_LEN);
  localparam int VEC_W  = VECTOR_LEN * PIXEL_W;

  logic              wr_en;
  logic [CIDX_W-1:0] wr_class;
  logic [NIDX_W-1:0] wr_node;
  logic              wr_valid;
  logic [VEC_W-1:0]  wr_w;
  logic [DIST_W-1:0] wr_th;
  logic              start;
  logic [CIDX_W-1:0] start_class;
  logic [VEC_W-1:0]  start_x;
  logic              mode;
  logic              busy;
  logic              done;
  logic [NIDX_W-1:0] win1_idx;
  logic [DIST_W-1:0] win1_dist;
  logic [NIDX_W-1:0] win2_idx;
  logic [DIST_W-1:0] win2_dist;
  logic              novel;

  modport master (
    output wr_en, wr_class, wr_node, wr_valid, wr_w, wr_th,
    output start, start_class, start_x, mode,
    input  busy, done, win1_idx, win1_dist, win2_idx, win2_dist, novel
  );

  modport slave (
    input  wr_en, wr_class, wr_node, wr_valid, wr_w, wr_th,
    input  start, start_class, start_x, mode,
    output busy, done, win1_idx, win1_dist, win2_idx, win2_dist, novel
  );
endinterface

// File: rtl/gam_winner_search.sv
// Winner-search engine: scans one class of stored nodes, one node per cycle,
// and reports the nearest and second-nearest node plus a novelty flag.
module gam_winner_search #(
  parameter int NODE_COUNT  = 10,
  parameter int CLASS_COUNT = 4,
  parameter int VECTOR_LEN  = 4,
  parameter int PIXEL_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  gam_winner_search_if.slave bus
);
  localparam int NIDX_W = $clog2(NODE_COUNT + 1);
  localparam int CIDX_W = $clog2(CLASS_COUNT + 1);
  localparam int DIST_W = 2 * PIXEL_W + $clog2(VECTOR_LEN);
  localparam int VEC_W  = VECTOR_LEN * PIXEL_W;
  localparam logic [DIST_W-1:0] DMAX = {DIST_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state_r, state_nx_s;
  logic              load_s, eval_s, fin_s, busy_nx_s;

  logic              valid_r [CLASS_COUNT][NODE_COUNT];
  logic [VEC_W-1:0]  w_r     [CLASS_COUNT][NODE_COUNT];
  logic [DIST_W-1:0] th_r    [CLASS_COUNT][NODE_COUNT];

  logic [VEC_W-1:0]  x_r;
  logic [CIDX_W-1:0] cls_r;
  logic              mode_r;
  logic [NIDX_W-1:0] ptr_r;
  logic [NIDX_W-1:0] best1_idx_r, best2_idx_r;
  logic [DIST_W-1:0] best1_dist_r, best2_dist_r, best1_th_r;

  logic              rd_valid_s;
  logic [VEC_W-1:0]  rd_w_s;
  logic [DIST_W-1:0] rd_th_s;
  logic [DIST_W-1:0] d_s;

  logic              busy_r, done_r, novel_r;
  logic [NIDX_W-1:0] win1_idx_r, win2_idx_r;
  logic [DIST_W-1:0] win1_dist_r, win2_dist_r;

  // Manhattan or squared-Euclidean distance; element differences are unsigned magnitudes.
  function automatic logic [DIST_W-1:0] dist_f(input logic [VEC_W-1:0] x,
                                              input logic [VEC_W-1:0] w,
                                              input logic             md);
    logic [DIST_W-1:0]    acc;
    logic [PIXEL_W-1:0]   xe, we, df;
    logic [2*PIXEL_W-1:0] sq;
    acc = {DIST_W{1'b0}};
    for (int i = 0; i < VECTOR_LEN; i++) begin
      xe = x[i*PIXEL_W +: PIXEL_W];
      we = w[i*PIXEL_W +: PIXEL_W];
      df = (xe >= we) ? (xe - we) : (we - xe);
      sq = (2*PIXEL_W)'(df) * (2*PIXEL_W)'(df);
      if (md) begin
        acc = acc + DIST_W'(sq);
      end else begin
        acc = acc + DIST_W'(df);
      end
    end
    return acc;
  endfunction

  // Validity flags: cleared by reset, updated by in-range writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CLASS_COUNT; c++)
        for (int n = 0; n < NODE_COUNT; n++)
          valid_r[c][n] <= 1'b0;
    end else if (bus.wr_en) begin
      for (int c = 0; c < CLASS_COUNT; c++)
        for (int n = 0; n < NODE_COUNT; n++)
          if (bus.wr_class == CIDX_W'(c + 1) && bus.wr_node == NIDX_W'(n + 1))
            valid_r[c][n] <= bus.wr_valid;
    end
  end

  // Weight and threshold storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      for (int c = 0; c < CLASS_COUNT; c++)
        for (int n = 0; n < NODE_COUNT; n++)
          if (bus.wr_class == CIDX_W'(c + 1) && bus.wr_node == NIDX_W'(n + 1)) begin
            w_r[c][n]  <= bus.wr_w;
            th_r[c][n] <= bus.wr_th;
          end
    end
  end

  // Read port for the node under scan; an unmatched class reads back as invalid.
  always_comb begin
    rd_valid_s = 1'b0;
    rd_w_s     = {VEC_W{1'b0}};
    rd_th_s    = {DIST_W{1'b0}};
    for (int c = 0; c < CLASS_COUNT; c++)
      for (int n = 0; n < NODE_COUNT; n++)
        if (cls_r == CIDX_W'(c + 1) && ptr_r == NIDX_W'(n + 1)) begin
          rd_valid_s = valid_r[c][n];
          rd_w_s     = w_r[c][n];
          rd_th_s    = th_r[c][n];
        end
    d_s = dist_f(x_r, rd_w_s, mode_r);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = IDLE;
    case (state_r)
      IDLE:    state_nx_s = bus.start ? SCAN : IDLE;
      SCAN:    state_nx_s = (ptr_r == NIDX_W'(NODE_COUNT)) ? FINISH : SCAN;
      FINISH:  state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM control decode.
  always_comb begin
    load_s    = 1'b0;
    eval_s    = 1'b0;
    fin_s     = 1'b0;
    case (state_r)
      IDLE:    load_s = bus.start;
      SCAN:    eval_s = 1'b1;
      FINISH:  fin_s  = 1'b1;
      default: load_s = 1'b0;
    endcase
    busy_nx_s = (state_nx_s != IDLE);
  end

  // Request latch and running best/second-best tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r          <= {VEC_W{1'b0}};
      cls_r        <= {CIDX_W{1'b0}};
      mode_r       <= 1'b0;
      ptr_r        <= {NIDX_W{1'b0}};
      best1_idx_r  <= {NIDX_W{1'b0}};
      best1_dist_r <= DMAX;
      best1_th_r   <= {DIST_W{1'b0}};
      best2_idx_r  <= {NIDX_W{1'b0}};
      best2_dist_r <= DMAX;
    end else if (load_s) begin
      x_r          <= bus.start_x;
      cls_r        <= bus.start_class;
      mode_r       <= bus.mode;
      ptr_r        <= NIDX_W'(1);
      best1_idx_r  <= {NIDX_W{1'b0}};
      best1_dist_r <= DMAX;
      best1_th_r   <= {DIST_W{1'b0}};
      best2_idx_r  <= {NIDX_W{1'b0}};
      best2_dist_r <= DMAX;
    end else if (eval_s) begin
      // Strict compares on an ascending scan keep the lower index on ties.
      if (rd_valid_s && d_s < best1_dist_r) begin
        best2_idx_r  <= best1_idx_r;
        best2_dist_r <= best1_dist_r;
        best1_idx_r  <= ptr_r;
        best1_dist_r <= d_s;
        best1_th_r   <= rd_th_s;
      end else if (rd_valid_s && d_s < best2_dist_r) begin
        best2_idx_r  <= ptr_r;
        best2_dist_r <= d_s;
      end else begin
        best2_idx_r  <= best2_idx_r;
      end
      if (ptr_r != NIDX_W'(NODE_COUNT)) begin
        ptr_r <= ptr_r + NIDX_W'(1);
      end else begin
        ptr_r <= ptr_r;
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Registered result outputs, held until the next search completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      novel_r     <= 1'b0;
      win1_idx_r  <= {NIDX_W{1'b0}};
      win1_dist_r <= {DIST_W{1'b0}};
      win2_idx_r  <= {NIDX_W{1'b0}};
      win2_dist_r <= {DIST_W{1'b0}};
    end else begin
      busy_r <= busy_nx_s;
      done_r <= fin_s;
      if (fin_s) begin
        win1_idx_r  <= best1_idx_r;
        win1_dist_r <= best1_dist_r;
        win2_idx_r  <= best2_idx_r;
        win2_dist_r <= best2_dist_r;
        novel_r     <= (best1_idx_r == {NIDX_W{1'b0}}) | (best1_dist_r > best1_th_r);
      end else begin
        novel_r     <= novel_r;
      end
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.novel     = novel_r;
  assign bus.win1_idx  = win1_idx_r;
  assign bus.win1_dist = win1_dist_r;
  assign bus.win2_idx  = win2_idx_r;
  assign bus.win2_dist = win2_dist_r;
endmodule

// File: tb/tb_gam_winner_search.sv
// Scoreboard bench for gam_winner_search: expected results are queued at request time
// and compared when done pulses.
module tb_gam_winner_search;
  localparam int N      = 10;
  localparam int C      = 4;
  localparam int NIDX_W = 4;
  localparam int CIDX_W = 3;
  localparam int DIST_W = 18;
  localparam int DMAX   = (1 << DIST_W) - 1;

  typedef struct {
    int i1; int d1; int i2; int d2; int nv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gam_winner_search_if #(.NODE_COUNT(N), .CLASS_COUNT(C), .VECTOR_LEN(4), .PIXEL_W(8)) bus ();

  gam_winner_search #(.NODE_COUNT(N), .CLASS_COUNT(C), .VECTOR_LEN(4), .PIXEL_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  bit          m_valid [1:C][1:N];
  logic [31:0] m_w     [1:C][1:N];
  int          m_th    [1:C][1:N];

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rep(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {b, b, b, b};
  endfunction

  function automatic exp_t mk(input int i1, d1, i2, d2, nv);
    exp_t e;
    e.i1 = i1; e.d1 = d1; e.i2 = i2; e.d2 = d2; e.nv = nv;
    return e;
  endfunction

  function automatic int mdist(input logic [31:0] x, input logic [31:0] w, input bit md);
    int s, a;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      a = int'(x[i*8 +: 8]) - int'(w[i*8 +: 8]);
      if (a < 0) a = -a;
      s += md ? a * a : a;
    end
    return s;
  endfunction

  // Reference: rank valid nodes by (distance, index) and take the first two.
  function automatic exp_t model(input int c, input logic [31:0] x, input bit md);
    exp_t e;
    int   d [1:N];
    e = mk(0, DMAX, 0, DMAX, 1);
    for (int n = 1; n <= N; n++) d[n] = m_valid[c][n] ? mdist(x, m_w[c][n], md) : -1;
    for (int n = 1; n <= N; n++)
      if (d[n] >= 0 && (e.i1 == 0 || d[n] < e.d1)) begin e.i1 = n; e.d1 = d[n]; end
    for (int n = 1; n <= N; n++)
      if (d[n] >= 0 && n != e.i1 && (e.i2 == 0 || d[n] < e.d2)) begin e.i2 = n; e.d2 = d[n]; end
    e.nv = (e.i1 == 0) ? 1 : ((e.d1 > m_th[c][e.i1]) ? 1 : 0);
    return e;
  endfunction

  task automatic write_node(input int c, input int n, input bit v, input logic [31:0] w, input int th);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_class = CIDX_W'(c); bus.wr_node = NIDX_W'(n);
    bus.wr_valid = v; bus.wr_w = w; bus.wr_th = DIST_W'(th);
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
    if (c >= 1 && c <= C && n >= 1 && n <= N) begin
      m_valid[c][n] = v; m_w[c][n] = w; m_th[c][n] = th;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_w1i"}, int'(bus.win1_idx), 0);
    check({tag, "_w1d"}, int'(bus.win1_dist), 0);
    check({tag, "_w2i"}, int'(bus.win2_idx), 0);
    check({tag, "_w2d"}, int'(bus.win2_dist), 0);
    check({tag, "_nov"}, int'(bus.novel), 0);
  endtask

  // inv_at: scan cycle at which node 7 of the class is invalidated (0 = never).
  task automatic run_search(input int c, input logic [31:0] x, input bit md, input exp_t e,
                            input int inv_at, input bit poke);
    int lat;
    bit got;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1; bus.start_class = CIDX_W'(c); bus.start_x = x; bus.mode = md;
    @(posedge clk);
    #1 bus.start = 1'b0;
    got = 1'b0; lat = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (k == inv_at) begin
        bus.wr_en = 1'b1; bus.wr_class = CIDX_W'(c); bus.wr_node = NIDX_W'(7); bus.wr_valid = 1'b0;
        m_valid[c][7] = 1'b0;
      end
      if (poke && k == 2) begin
        bus.start = 1'b1; bus.start_class = CIDX_W'(1); bus.start_x = rep(0);
      end
      @(posedge clk);
      #1 bus.wr_en = 1'b0; bus.start = 1'b0;
      if (k == 1) check("busy_high", int'(bus.busy), 1);
      if (bus.done === 1'b1) begin got = 1'b1; lat = k; end
    end
    check("done_seen", int'(got), 1);
    check("latency", lat, N + 1);
    check("busy_low_at_done", int'(bus.busy), 0);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("win1_idx", int'(bus.win1_idx), e.i1);
        check("win1_dist", int'(bus.win1_dist), e.d1);
        check("win2_idx", int'(bus.win2_idx), e.i2);
        check("win2_dist", int'(bus.win2_dist), e.d2);
        check("novel", int'(bus.novel), e.nv);
      end
    end
  end

  initial begin
    exp_t e_empty;
    e_empty = mk(0, DMAX, 0, DMAX, 1);
    bus.wr_en = 1'b0; bus.wr_class = '0; bus.wr_node = '0; bus.wr_valid = 1'b0;
    bus.wr_w = '0; bus.wr_th = '0; bus.start = 1'b0; bus.start_class = '0;
    bus.start_x = '0; bus.mode = 1'b0;
    for (int c = 1; c <= C; c++)
      for (int n = 1; n <= N; n++) begin m_valid[c][n] = 1'b0; m_w[c][n] = '0; m_th[c][n] = 0; end

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk) rst_n = 1'b1;

    run_search(1, rep(0), 1'b0, e_empty, 0, 1'b0);

    write_node(2, 1, 1'b1, rep(10), 20);
    write_node(2, 3, 1'b1, rep(0), 5);
    write_node(2, 5, 1'b1, rep(50), 100);
    run_search(2, rep(12), 1'b0, mk(1, 8, 3, 48, 0), 0, 1'b0);
    run_search(2, rep(15), 1'b0, mk(1, 20, 3, 60, 0), 0, 1'b1);
    run_search(2, rep(15), 1'b1, mk(1, 100, 3, 900, 1), 0, 1'b0);

    write_node(3, 2, 1'b1, rep(100), 1000);
    write_node(3, 4, 1'b1, rep(100), 1000);
    run_search(3, rep(90), 1'b0, mk(2, 40, 4, 40, 0), 0, 1'b0);

    write_node(0, 1, 1'b1, rep(12), 1000);
    write_node(2, 11, 1'b1, rep(12), 1000);
    run_search(2, rep(12), 1'b0, mk(1, 8, 3, 48, 0), 0, 1'b0);

    write_node(2, 7, 1'b1, rep(12), 0);
    run_search(2, rep(12), 1'b0, mk(7, 0, 1, 8, 0), 0, 1'b0);
    run_search(2, rep(12), 1'b0, mk(1, 8, 3, 48, 0), 3, 1'b0);

    for (int n = 1; n <= N; n++)
      write_node(4, n, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 6000)));
    for (int r = 0; r < 4; r++) begin
      logic [31:0] x;
      bit md;
      x = $urandom; md = 1'(r);
      run_search(4, x, md, model(4, x, md), 0, 1'b0);
    end
    run_search(5, rep(12), 1'b0, e_empty, 0, 1'b0);

    @(negedge clk);
    bus.start = 1'b1; bus.start_class = CIDX_W'(2); bus.start_x = rep(12); bus.mode = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("busy_async_rst", int'(bus.busy), 0);
    for (int c = 1; c <= C; c++)
      for (int n = 1; n <= N; n++) m_valid[c][n] = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    repeat (N + 4) @(negedge clk) check("no_done_after_rst", int'(bus.done), 0);
    run_search(2, rep(12), 1'b0, e_empty, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
